// File: rtl/rotate_step_controller_pkg.sv
// Shared constants and types for the rotate/shift step controller.
package rotate_step_controller_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROTATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rotate_step_controller_counter.sv
// Loadable down-counter that tracks the remaining rotate steps of a command.
module step_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             is_one
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority; decrement saturates at zero so the counter never wraps.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_one = (count_reg == CNT_W'(1));

endmodule

// File: rtl/rotate_step_controller.sv
// Drives an 8-bit rotating register through load + N rotate steps per command.
module rotate_step_controller
    import rotate_step_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_dir,
    input  logic             cmd_arith,
    input  logic [WIDTH-1:0] reg_q,
    output logic             reg_loadn,
    output logic             reg_rotate_right,
    output logic             reg_as_right,
    output logic [WIDTH-1:0] reg_data,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] count_reg;
    logic             dir_reg;
    logic             as_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             loadn_reg;
    logic             rr_reg;
    logic             asr_reg;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic             load_sel;

    assign cnt_load = (state_reg == ST_LOAD);
    assign cnt_dec  = (state_reg == ST_ROTATE);

    step_down_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk        (clk),
        .srst       (reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (count_reg),
        .is_one     (cnt_is_one)
    );

    // Control FSM; every output except reg_data is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            as_reg    <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            loadn_reg <= 1'b0;
            rr_reg    <= 1'b0;
            asr_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid && ready_reg) begin
                        data_reg  <= cmd_data;
                        count_reg <= cmd_count;
                        dir_reg   <= cmd_dir;
                        // Arithmetic shift only exists to the right; left stays a rotate.
                        as_reg    <= cmd_arith & (cmd_dir == DIR_RIGHT);
                        state_reg <= ST_LOAD;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        loadn_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (count_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        loadn_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_ROTATE;
                        loadn_reg <= 1'b1;
                        rr_reg    <= dir_reg;
                        asr_reg   <= as_reg;
                    end
                end
                ST_ROTATE: begin
                    // Counter was loaded with count, so count cycles elapse before it reads 1 here.
                    if (cnt_is_one) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        loadn_reg <= 1'b0;
                        rr_reg    <= 1'b0;
                        asr_reg   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    loadn_reg <= 1'b0;
                    rr_reg    <= 1'b0;
                    asr_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign load_sel = (state_reg == ST_LOAD);

    // Register data: latched value while loading, otherwise recirculate reg_q to hold.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_data_mux
            assign reg_data[gi] = load_sel ? data_reg[gi] : reg_q[gi];
        end
    endgenerate

    assign cmd_ready        = ready_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign reg_loadn        = loadn_reg;
    assign reg_rotate_right = rr_reg;
    assign reg_as_right     = asr_reg;

endmodule

// File: tb/tb_rotate_step_controller.sv
// Bench for rotate_step_controller with a behavioural register and timeline model.
module tb_rotate_step_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_count = 4'h0;
    logic       cmd_dir = 1'b0;
    logic       cmd_arith = 1'b0;
    logic [7:0] reg_q = 8'hA5;
    logic       reg_loadn;
    logic       reg_rotate_right;
    logic       reg_as_right;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    rotate_step_controller dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_data         (cmd_data),
        .cmd_count        (cmd_count),
        .cmd_dir          (cmd_dir),
        .cmd_arith        (cmd_arith),
        .reg_q            (reg_q),
        .reg_loadn        (reg_loadn),
        .reg_rotate_right (reg_rotate_right),
        .reg_as_right     (reg_as_right),
        .reg_data         (reg_data),
        .busy             (busy),
        .done             (done)
    );

    // The controlled register: parallel load, rotate left/right, arithmetic shift right.
    always @(posedge clk) begin
        if (!reg_loadn)
            reg_q <= reg_data;
        else if (reg_rotate_right && reg_as_right)
            reg_q <= {reg_q[7], reg_q[7:1]};
        else if (reg_rotate_right)
            reg_q <= {reg_q[0], reg_q[7:1]};
        else
            reg_q <= {reg_q[6:0], reg_q[7]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Closed-form result of loading v then applying n steps.
    function automatic logic [7:0] expect_result(input logic [7:0] v, input int n,
                                                 input logic dir, input logic arith);
        int s;
        logic [7:0] r;
        s = n % 8;
        if (dir && arith)
            r = 8'($signed(v) >>> n);
        else if (dir)
            r = (v >> s) | (v << (8 - s));
        else
            r = (v << s) | (v >> (8 - s));
        return r;
    endfunction

    // Timeline model: offset counts cycles since the accepting edge.
    bit         m_active = 1'b0;
    int         m_off = 0;
    logic [7:0] m_data = 8'h00;
    int         m_cnt = 0;
    logic       m_dir = 1'b0;
    logic       m_as = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_off    <= 0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active <= 1'b1;
                m_off    <= 1;
                m_data   <= cmd_data;
                m_cnt    <= int'(cmd_count);
                m_dir    <= cmd_dir;
                m_as     <= cmd_arith & cmd_dir;
            end
        end else if (m_off == m_cnt + 2) begin
            m_active <= 1'b0;
            m_off    <= 0;
        end else begin
            m_off <= m_off + 1;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        logic       e_ready, e_busy, e_done, e_loadn, e_rr, e_as;
        logic [7:0] e_data;
        if (!reset) begin
            e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            e_loadn = 1'b0; e_rr = 1'b0; e_as = 1'b0; e_data = reg_q;
            if (m_active) begin
                e_ready = 1'b0;
                e_busy  = 1'b1;
                if (m_off == 1) begin
                    e_data = m_data;
                end else if (m_off <= m_cnt + 1) begin
                    e_loadn = 1'b1;
                    e_rr    = m_dir;
                    e_as    = m_as;
                end else begin
                    e_done = 1'b1;
                end
            end
            chk("cmd_ready", cmd_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("reg_loadn", reg_loadn, e_loadn);
            chk("reg_rotate_right", reg_rotate_right, e_rr);
            chk("reg_as_right", reg_as_right, e_as);
            chk("reg_data", reg_data, e_data);
            chk("ready_not_busy", cmd_ready, !busy);
            if (m_active && m_off == m_cnt + 2)
                chk("model_result", reg_q, expect_result(m_data, m_cnt, m_dir, m_as));
        end
    end

    // Issue one command, then check load data, rotate cycles, done latency and final value.
    task automatic run_cmd(input logic [7:0] d, input logic [3:0] c, input logic dir,
                           input logic arith, input logic [7:0] exp_q, input string tag);
        int k;
        int rot;
        bit seen;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = d; cmd_count = c; cmd_dir = dir; cmd_arith = arith;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 1; rot = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_load_data"}, reg_data, d);
            if (reg_loadn) rot++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_cycle"}, k, 2 + int'(c));
        chk({tag, "_rotate_cycles"}, rot, int'(c));
        chk({tag, "_final_q"}, reg_q, exp_q);
        @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle hold with A5 in the register.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_loadn", reg_loadn, 1'b0);
            chk("idle_data", reg_data, 8'hA5);
            chk("idle_ready", cmd_ready, 1'b1);
            chk("idle_done", done, 1'b0);
            @(posedge clk);
        end

        run_cmd(8'h81, 4'd1,  1'b1, 1'b0, 8'hC0, "ror1");
        run_cmd(8'h80, 4'd3,  1'b1, 1'b1, 8'hF0, "asr3");
        run_cmd(8'h01, 4'd0,  1'b0, 1'b0, 8'h01, "cnt0");
        run_cmd(8'h01, 4'd15, 1'b0, 1'b1, 8'h80, "rol15");
        run_cmd(8'h3C, 4'd2,  1'b1, 1'b0, 8'h0F, "ror2");

        // Hold cmd_valid during ROTATE, then reset mid-operation.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_count = 4'd10; cmd_dir = 1'b1; cmd_arith = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rot_valid_ignored_ready", cmd_ready, 1'b0);
        chk("rot_loadn", reg_loadn, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_loadn", reg_loadn, 1'b0);
        chk("rst_rr", reg_rotate_right, 1'b0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("rst_no_done", done, 1'b0);
        end

        // Controller still works after the abort.
        run_cmd(8'h80, 4'd1, 1'b0, 1'b0, 8'h01, "post_rst");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
